// File: rtl/router_out_drain_pkg.sv
// rtl/router_out_drain_pkg.sv - shared header field positions and framing state encodings
package router_out_drain_pkg;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_PAY = 2'd1,
        ST_PAR = 2'd2
    } drain_state_t;

    // Payload length carried in a header byte
    function automatic logic [LEN_W-1:0] hdr_len(input logic [LEN_MSB:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_skid2.sv
// rtl/router_skid2.sv - two-entry output queue with push/pop/flush
module router_skid2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;

    // ent0 is always the head; flush wins over a same-cycle push so late read data is dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stale entries never leak out: an empty queue presents zero
    assign dout = (occ != 2'd0) ? ent0 : '0;

endmodule

// File: rtl/router_out_drain.sv
// rtl/router_out_drain.sv - drains one router output FIFO to its client with framing and stall timeout
module router_out_drain
    import router_out_drain_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              soft_reset_out,
    input  logic              read_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out,
    output logic              sop,
    output logic              eop,
    output logic              parity_err
);

    logic [1:0]        occ;
    logic              pend;
    logic              transfer;
    logic [2:0]        in_flight;
    logic              stall_hit;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  rem;
    logic [DATA_W-1:0] par;
    drain_state_t      state;

    router_skid2 #(.DATA_W(DATA_W)) u_queue (
        .clk    (clk),
        .resetn (resetn),
        .push   (pend),
        .pop    (transfer),
        .flush  (stall_hit),
        .din    (fifo_data),
        .dout   (data_out),
        .occ    (occ)
    );

    assign vld_out  = (occ != 2'd0);
    assign transfer = vld_out & read_in;
    assign sop      = vld_out & (state == ST_HDR);
    assign eop      = vld_out & (state == ST_PAR);

    // Bytes held or on their way after this cycle; a read may issue only if a slot is guaranteed
    assign in_flight  = {1'b0, occ} + {2'b00, pend} - {2'b00, transfer};
    assign fifo_rd_en = resetn & ~fifo_empty & ~soft_reset_out & (in_flight < 3'd2);

    // A read_in in the final stalled cycle is a transfer, so it pre-empts the timeout
    assign stall_hit = vld_out & ~read_in & (stall_cnt == CNT_W'(TIMEOUT - 1));

    // Track the read whose data lands on the next edge; a timeout discards it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pend <= 1'b0;
        else         pend <= stall_hit ? 1'b0 : fifo_rd_en;
    end

    // Count consecutive stalled cycles and fire a one-cycle FIFO soft reset on timeout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt      <= '0;
            soft_reset_out <= 1'b0;
        end else begin
            soft_reset_out <= stall_hit;
            if (stall_hit)
                stall_cnt <= '0;
            else if (vld_out & ~read_in)
                stall_cnt <= stall_cnt + CNT_W'(1);
            else
                stall_cnt <= '0;
        end
    end

    // Packet framing and parity, advanced once per accepted byte
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_HDR;
            rem        <= '0;
            par        <= '0;
            parity_err <= 1'b0;
        end else if (stall_hit) begin
            state      <= ST_HDR;
            rem        <= '0;
            par        <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (transfer) begin
                case (state)
                    ST_HDR: begin
                        rem   <= CNT_W'(hdr_len(data_out[LEN_MSB:0]));
                        par   <= data_out;
                        state <= (hdr_len(data_out[LEN_MSB:0]) == '0) ? ST_PAR : ST_PAY;
                    end
                    ST_PAY: begin
                        par <= par ^ data_out;
                        rem <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) state <= ST_PAR;
                    end
                    ST_PAR: begin
                        parity_err <= (data_out != par);
                        state      <= ST_HDR;
                    end
                    default: state <= ST_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_out_drain.sv
// tb/tb_router_out_drain.sv - scoreboard bench for router_out_drain
module tb_router_out_drain;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       read_in = 1'b0;
    logic       fifo_rd_en, soft_reset_out, vld_out, sop, eop, parity_err;
    logic [7:0] data_out;

    router_out_drain #(.DATA_W(8), .TIMEOUT(30), .CNT_W(6)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .fifo_rd_en     (fifo_rd_en),
        .soft_reset_out (soft_reset_out),
        .read_in        (read_in),
        .vld_out        (vld_out),
        .data_out       (data_out),
        .sop            (sop),
        .eop            (eop),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       sop;
        logic       eop;
        logic       perr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] feed_q[$];
    logic [7:0] stg[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   first_xfer = 0;
    int   last_xfer = 0;
    int   rd_empty_viol = 0;
    int   stray_perr = 0;
    int   perr_seen = 0;
    int   perr_exp = 0;
    logic chk_perr_next = 1'b0;
    logic exp_perr_val = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: data appears one cycle after the strobe; soft reset empties it
    always @(posedge clk) begin : fifo_model
        logic rd, sr;
        cyc++;
        rd = fifo_rd_en;
        sr = soft_reset_out;
        if (rd && fifo_q.size() == 0) rd_empty_viol++;
        #1;
        if (sr || !resetn) fifo_q.delete();
        else if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    // Monitor: every client transfer is popped from the scoreboard and compared
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn) begin
            if (chk_perr_next) begin
                check("perr", 32'(parity_err), 32'(exp_perr_val));
                chk_perr_next = 1'b0;
            end else if (parity_err) begin
                stray_perr++;
            end
            if (parity_err) perr_seen++;
            if (vld_out && read_in) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'(data_out), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(data_out), 32'(e.b));
                    check("sop", 32'(sop), 32'(e.sop));
                    check("eop", 32'(eop), 32'(e.eop));
                    if (e.eop) begin
                        chk_perr_next = 1'b1;
                        exp_perr_val  = e.perr;
                    end
                end
                if (xfer_cnt == 0) first_xfer = cyc;
                last_xfer = cyc;
                xfer_cnt++;
            end
        end
    end

    task automatic commit_stage();
        logic [7:0] h, x;
        int len;
        exp_t e;
        h = stg[0];
        len = int'(h[7:2]);
        x = 8'h00;
        for (int i = 0; i < stg.size(); i++) begin
            e.b    = stg[i];
            e.sop  = (i == 0);
            e.eop  = (i == len + 1);
            e.perr = 1'b0;
            if (i <= len) begin
                x = x ^ stg[i];
            end else begin
                e.perr = (stg[i] != x);
                if (e.perr) perr_exp++;
            end
            exp_q.push_back(e);
            feed_q.push_back(stg[i]);
        end
        stg.delete();
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++)
            if (feed_q.size() > 0) fifo_q.push_back(feed_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic load5(input logic [7:0] a, b, c, d, e);
        stg.push_back(a); stg.push_back(b); stg.push_back(c); stg.push_back(d); stg.push_back(e);
        commit_stage();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vld_out) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check(tag, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_out && n < 40);
        if (!vld_out) check(tag, 32'(vld_out), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stim
        int p0, n;
        logic [7:0] h, x;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", 32'({vld_out, sop, eop, parity_err, soft_reset_out, fifo_rd_en, data_out}), 32'd0);
        @(posedge clk); #2 resetn = 1'b1;

        // 1: reset in the middle of a packet
        read_in = 1'b1;
        load5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        load5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        @(posedge clk); #2 feed(10);
        n = 0;
        while (xfer_cnt < 2 && n < 20) begin @(negedge clk); n++; end
        check("t1_started", 32'(xfer_cnt >= 2), 32'd1);
        @(posedge clk); #3 resetn = 1'b0;
        #1 check("rst_mid", 32'({vld_out, sop, eop, parity_err, soft_reset_out, fifo_rd_en, data_out}), 32'd0);
        exp_q.delete(); feed_q.delete(); fifo_q.delete(); fifo_empty = 1'b1;
        chk_perr_next = 1'b0; perr_seen = 0; perr_exp = 0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        // 2: good packet, back-to-back transfers
        xfer_cnt = 0;
        load5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        @(posedge clk); #2 feed(5);
        wait_idle("t2_idle", 60);
        check("t2_cnt", 32'(xfer_cnt), 32'd5);
        check("t2_span", 32'(last_xfer - first_xfer), 32'd4);

        // 3: bad parity byte
        p0 = perr_seen;
        load5(8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF);
        @(posedge clk); #2 feed(5);
        wait_idle("t3_idle", 60);
        check("t3_perr_cnt", 32'(perr_seen - p0), 32'd1);

        // 4: zero-length packet
        xfer_cnt = 0;
        stg.push_back(8'h02); stg.push_back(8'h02); commit_stage();
        @(posedge clk); #2 feed(2);
        wait_idle("t4_idle", 60);
        check("t4_cnt", 32'(xfer_cnt), 32'd2);

        // 5: client stalls for the full timeout
        @(posedge clk); #2 read_in = 1'b0;
        load5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        feed(5);
        wait_vld("t5_vld_a");
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if (k == 30) check("t5_pre", 32'(soft_reset_out), 32'd0);
        end
        @(negedge clk);
        check("t5_sro", 32'(soft_reset_out), 32'd1);
        check("t5_vld", 32'(vld_out), 32'd0);
        @(negedge clk);
        check("t5_sro_off", 32'(soft_reset_out), 32'd0);
        check("t5_vld_off", 32'(vld_out), 32'd0);
        exp_q.delete(); feed_q.delete();
        @(posedge clk); #2;
        check("t5_fifo_flushed", 32'(fifo_q.size()), 32'd0);

        // 5b: read_in arrives in the 30th stalled cycle
        xfer_cnt = 0;
        load5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        feed(5);
        wait_vld("t5_vld_b");
        for (int k = 2; k <= 29; k++) @(negedge clk);
        @(posedge clk); #2 read_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5b_no_sro", 32'(soft_reset_out), 32'd0);
        wait_idle("t5b_idle", 60);
        check("t5b_cnt", 32'(xfer_cnt), 32'd5);

        // 6: 10-byte packet, toggling client, bursty refill
        xfer_cnt = 0;
        h = {6'd8, 2'd2};
        x = h;
        stg.push_back(h);
        for (int i = 0; i < 8; i++) begin
            stg.push_back(8'(8'h40 + i));
            x = x ^ 8'(8'h40 + i);
        end
        stg.push_back(x);
        commit_stage();
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk); #2 read_in = ~read_in;
                end
            end
            begin
                while (feed_q.size() > 0) begin
                    @(posedge clk); #2 feed(3);
                    repeat (5) @(posedge clk);
                end
            end
        join
        read_in = 1'b1;
        wait_idle("t6_idle", 60);
        check("t6_cnt", 32'(xfer_cnt), 32'd10);

        // random packets, random client, occasional bad parity
        for (int p = 0; p < 6; p++) begin
            h = {6'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
            x = h;
            stg.push_back(h);
            for (int i = 0; i < int'(h[7:2]); i++) begin
                logic [7:0] r;
                r = 8'($urandom);
                stg.push_back(r);
                x = x ^ r;
            end
            stg.push_back(($urandom_range(0, 2) == 0) ? ~x : x);
            commit_stage();
        end
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk); #2 read_in = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                while (feed_q.size() > 0) begin
                    @(posedge clk); #2 feed($urandom_range(1, 4));
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                end
            end
        join
        read_in = 1'b1;
        wait_idle("rnd_idle", 100);

        check("rd_while_empty", 32'(rd_empty_viol), 32'd0);
        check("stray_perr", 32'(stray_perr), 32'd0);
        check("perr_total", 32'(perr_seen), 32'(perr_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
